// File: rtl/secure_lsu.sv
// secure_lsu: load/store unit with a key-protected address window.
//
// A load or store is latched in IDLE, checked for alignment and window
// access rights, then issued on a simple req/gnt + rvalid memory port.
// Loads write back through a one-cycle register-file strobe. A violation
// or a stalled memory produces a one-cycle fault pulse with a sticky cause
// code and address.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   load_on, store_on      start a load / store (sampled in IDLE only)
//   rd_addr                load destination register
//   eff_addr               byte address of the access
//   store_data             store operand
//   key_access             key presented for the secure window
//   busy                   high whenever the FSM is not idle
//   mem_req/we/addr/wdata  memory request channel
//   mem_gnt                request accepted
//   mem_rvalid/rdata       read response
//   wb_en/addr/data        register-file write-back strobe
//   fault/fault_code       fault pulse and sticky cause (1 misaligned,
//                          2 key mismatch, 3 timeout)
//   fault_addr             address of the last faulting access
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for load_on / store_on
// CHECK  | one cycle of alignment and key checks on the latched access
// REQ    | mem_req held until mem_gnt or timeout
// WAIT_R | load granted, waiting for mem_rvalid or timeout
// WB     | one-cycle register-file write-back
// FAULT  | one-cycle fault pulse, then back to IDLE
module secure_lsu #(
    parameter logic [15:0] KEY       = 16'h0032,
    parameter logic [31:0] SEC_BASE  = 32'h0000_F000,
    parameter logic [31:0] SEC_LIMIT = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_on,
    input  logic        store_on,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] eff_addr,
    input  logic [31:0] store_data,
    input  logic [15:0] key_access,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT_R = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_rst_sync;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    logic [15:0] r_key;
    logic        r_store;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_fault_code;
    logic [31:0] r_fault_addr;

    logic        w_secure;
    logic        w_tmo;
    logic        w_fault_set;
    logic [1:0]  w_code;
    logic        w_start;

    // Reset release is retimed so the FSM never leaves IDLE on the
    // cycle rst_n happens to rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_secure = (r_addr >= SEC_BASE) && (r_addr <= SEC_LIMIT);
    // >= rather than == so a load granted on the last allowed cycle still
    // times out in WAIT_R unless rvalid arrives immediately.
    assign w_tmo    = (r_cnt >= TMO_LAST);
    assign w_start  = r_rst_sync[1] && (load_on || store_on);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        w_code      = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_addr[1:0] != 2'b00) begin
                    w_next      = S_FAULT;
                    w_fault_set = 1'b1;
                    w_code      = 2'd1;
                end else if (w_secure && (r_key != KEY)) begin
                    w_next      = S_FAULT;
                    w_fault_set = 1'b1;
                    w_code      = 2'd2;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                // A grant on the final cycle beats the timeout.
                if (mem_gnt) begin
                    w_next = r_store ? S_IDLE : S_WAIT_R;
                end else if (w_tmo) begin
                    w_next      = S_FAULT;
                    w_fault_set = 1'b1;
                    w_code      = 2'd3;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    w_next = S_WB;
                end else if (w_tmo) begin
                    w_next      = S_FAULT;
                    w_fault_set = 1'b1;
                    w_code      = 2'd3;
                end
            end
            S_WB:    w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_rd         <= '0;
            r_key        <= '0;
            r_store      <= 1'b0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_fault_code <= '0;
            r_fault_addr <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_start) begin
                r_addr  <= eff_addr;
                r_data  <= store_data;
                r_rd    <= rd_addr;
                r_key   <= key_access;
                r_store <= store_on;
            end
            if (r_state == S_CHECK) begin
                r_cnt <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT_R)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if ((r_state == S_WAIT_R) && mem_rvalid) begin
                r_rdata <= mem_rdata;
            end
            if (w_fault_set) begin
                r_fault_code <= w_code;
                r_fault_addr <= r_addr;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign mem_req    = (r_state == S_REQ);
    assign mem_we     = mem_req && r_store;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_data;
    // Register 0 is hard-wired; the load still runs through WB.
    assign wb_en      = (r_state == S_WB) && (r_rd != 5'd0);
    assign wb_addr    = r_rd;
    assign wb_data    = r_rdata;
    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_fault_code;
    assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_secure_lsu.sv
module tb_secure_lsu;

    localparam logic [15:0] KEY       = 16'h0032;
    localparam logic [31:0] SEC_BASE  = 32'h0000_F000;
    localparam logic [31:0] SEC_LIMIT = 32'h0000_FFFF;
    localparam int          T         = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_on = 1'b0, store_on = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] eff_addr = '0, store_data = '0;
    logic [15:0] key_access = '0;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;

    secure_lsu #(.KEY(KEY), .SEC_BASE(SEC_BASE), .SEC_LIMIT(SEC_LIMIT), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .load_on(load_on), .store_on(store_on),
        .rd_addr(rd_addr), .eff_addr(eff_addr), .store_data(store_data),
        .key_access(key_access), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .fault(fault),
        .fault_code(fault_code), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // kind: 0 accepted memory request, 1 write-back, 2 fault
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [1:0] last_code = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input logic we);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d; e.we = we;
        q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [31:0] a, input logic [31:0] d, input logic we);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected nothing", kind, a, d);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_addr", a, e.a);
            if (kind == 0) begin
                chk("mem_we", {31'b0, we}, {31'b0, e.we});
                if (e.we) chk("mem_wdata", d, e.d);
            end else begin
                chk("event_data", d, e.d);
            end
        end
    endtask

    // Monitor: samples just after the falling edge, once drivers have settled.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (mem_req && mem_gnt) got(0, mem_addr, mem_wdata, mem_we);
            if (wb_en)              got(1, {27'b0, wb_addr}, wb_data, 1'b0);
            if (fault)              got(2, fault_addr, {30'b0, fault_code}, 1'b0);
        end
    end

    function automatic bit in_window(input logic [31:0] a);
        return (a >= SEC_BASE) && (a <= SEC_LIMIT);
    endfunction

    // One transaction: the reference model predicts the observable events,
    // busy latency (command cycle to busy low) and number of mem_req cycles.
    task automatic run_txn(input bit st, input bit ld, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd,
                           input logic [15:0] key, input int gdly, input int rdly,
                           input logic [31:0] rdat);
        int  lat_exp, req_exp, rc, wc, lat;
        bit  granted, done;
        bit  is_store;
        is_store = st;
        req_exp  = 0;
        if (addr[1:0] != 2'b00) begin
            push(2, addr, 32'd1, 1'b0); last_code = 2'd1; lat_exp = 3;
        end else if (in_window(addr) && key != KEY) begin
            push(2, addr, 32'd2, 1'b0); last_code = 2'd2; lat_exp = 3;
        end else if (gdly + 1 > T) begin
            push(2, addr, 32'd3, 1'b0); last_code = 2'd3; lat_exp = T + 3; req_exp = T;
        end else begin
            push(0, addr, data, is_store);
            req_exp = gdly + 1;
            if (is_store) begin
                lat_exp = gdly + 3;
            end else if (gdly + rdly + 2 > T) begin
                push(2, addr, 32'd3, 1'b0); last_code = 2'd3; lat_exp = T + 3;
            end else begin
                if (rd != 5'd0) push(1, {27'b0, rd}, rdat, 1'b0);
                lat_exp = gdly + rdly + 5;
            end
        end

        @(negedge clk);
        load_on = ld; store_on = st; eff_addr = addr; store_data = data;
        rd_addr = rd; key_access = key;
        @(negedge clk);
        rc = 0; wc = 0; granted = 0; done = 0; lat = 0;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            load_on = 0; store_on = 0; mem_gnt = 0; mem_rvalid = 0;
            mem_rdata = $urandom;
            if (!busy) begin
                done = 1; lat = c + 1;
                break;
            end
            // inputs change freely while busy; none of it may be taken
            load_on = 1'($urandom); store_on = 1'($urandom);
            eff_addr = $urandom; store_data = $urandom;
            rd_addr = 5'($urandom); key_access = 16'($urandom);
            if (mem_req) begin
                mem_gnt = (rc == gdly);
                if (mem_gnt) granted = 1;
                rc++;
            end else if (granted && !is_store) begin
                mem_rvalid = (wc == rdly);
                if (mem_rvalid) mem_rdata = rdat;
                wc++;
            end
        end
        load_on = 0; store_on = 0;
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL busy_timeout: busy still high after 80 cycles, expected idle");
        end
        chk("busy_latency", lat, lat_exp);
        chk("mem_req_cycles", rc, req_exp);
        #2;
        chk("events_pending", q.size(), 0);
        chk("fault_code_hold", {30'b0, fault_code}, {30'b0, last_code});
        q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, rdat;
        logic [15:0] k;
        int sel, mode, g, r;

        #23;
        chk("reset_outputs", {busy, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr,
                              wb_data, fault, fault_code, fault_addr} != 0, 0);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // directed cases
        run_txn(1, 0, 32'h100, 32'hDEADBEEF, 5'd0, KEY, 0, 0, 32'h0);
        run_txn(0, 1, 32'h200, 32'h0, 5'd5, KEY, 2, 0, 32'h12345678);
        run_txn(1, 0, 32'h0000_F010, 32'hCAFEF00D, 5'd0, 16'h0031, 0, 0, 32'h0);
        run_txn(1, 0, 32'h0000_F010, 32'hCAFEF00D, 5'd0, 16'h0032, 1, 0, 32'h0);
        run_txn(0, 1, 32'h102, 32'h0, 5'd3, KEY, 0, 0, 32'h0);
        run_txn(0, 1, 32'h400, 32'h0, 5'd9, KEY, 100, 0, 32'h55AA55AA);
        // late response after the timeout must be ignored
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        @(negedge clk); mem_rvalid = 0;
        repeat (2) @(negedge clk);
        chk("late_rvalid_code", {30'b0, fault_code}, 32'd3);
        run_txn(1, 0, 32'h0000_0FFC, 32'h01020304, 5'd0, KEY, T - 1, 0, 32'h0);
        run_txn(0, 1, 32'h0000_EFFC, 32'h0, 5'd12, 16'h0, 3, T - 5, 32'hA5A5_0001);
        run_txn(0, 1, 32'h0000_EFF8, 32'h0, 5'd12, 16'h0, 3, T - 4, 32'hA5A5_0002);
        run_txn(0, 1, 32'h0001_0000, 32'h0, 5'd0, 16'h0, 0, 1, 32'h77777777);
        run_txn(1, 1, 32'h0000_0040, 32'h89ABCDEF, 5'd4, KEY, 0, 0, 32'h0);
        run_txn(0, 1, 32'h0000_F000, 32'h0, 5'd1, 16'h0033, 0, 0, 32'h0);
        run_txn(0, 1, 32'h0000_FFFC, 32'h0, 5'd31, KEY, 0, 0, 32'hFEEDFACE);

        // reset during WAIT_R
        push(0, 32'h300, 32'h0, 1'b0);
        @(negedge clk);
        load_on = 1; eff_addr = 32'h300; rd_addr = 5'd7; key_access = KEY;
        @(negedge clk); load_on = 0;
        @(negedge clk); mem_gnt = 1;
        @(negedge clk); mem_gnt = 0;
        #3 rst_n = 0;
        #1;
        chk("async_reset_busy", {31'b0, busy}, 0);
        chk("async_reset_outputs", {busy, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr,
                                    wb_data, fault, fault_code, fault_addr} != 0, 0);
        chk("reset_event_seen", q.size(), 0);
        q.delete();
        last_code = 2'd0;
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk); mem_rvalid = 0;
        #2 rst_n = 1;
        repeat (4) @(negedge clk);
        run_txn(0, 1, 32'h300, 32'h0, 5'd7, KEY, 0, 0, 32'h3333_4444);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                a = $urandom; a[1:0] = 2'($urandom_range(1, 3));
            end else if (sel < 5) begin
                a = SEC_BASE + ($urandom_range(0, 1023) << 2);
            end else begin
                a = $urandom & 32'h0001_FFFC;
            end
            k    = ($urandom_range(0, 1) == 0) ? KEY : 16'($urandom);
            mode = $urandom_range(0, 2);
            g    = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 3) : $urandom_range(4, 20);
            r    = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 14);
            if (mode == 0 && g == T - 1) g = T;
            d    = $urandom;
            rdat = $urandom;
            run_txn(mode != 0, mode != 1, a, d, 5'($urandom_range(0, 31)), k, g, r, rdat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
